// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: default bus widths and
// the FSM state encoding.
package bus_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arbState_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Two-master request/ack ports plus the single-slave bus. The master modport is
// the arbiter's view; the slave modport is the view of the masters and slave.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              m0_req;
    logic              m0_write;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_write;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic              bSel;
    logic              bWrite;
    logic [ADDR_W-1:0] bAddr;
    logic [DATA_W-1:0] bWData;
    logic [DATA_W-1:0] bRData;
    logic              busy;

    modport master (
        input  m0_req, m0_write, m0_addr, m0_wdata,
        input  m1_req, m1_write, m1_addr, m1_wdata,
        input  bRData,
        output m0_gnt, m0_ack, m0_rdata,
        output m1_gnt, m1_ack, m1_rdata,
        output bSel, bWrite, bAddr, bWData, busy
    );

    modport slave (
        output m0_req, m0_write, m0_addr, m0_wdata,
        output m1_req, m1_write, m1_addr, m1_wdata,
        output bRData,
        input  m0_gnt, m0_ack, m0_rdata,
        input  m1_gnt, m1_ack, m1_rdata,
        input  bSel, bWrite, bAddr, bWData, busy
    );

endinterface

// File: rtl/bus_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational winner, registered preference
// pointer that flips away from the master just served.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       lastWinner,
    output logic       winner
);

    logic ptr;

    // NOTE: assign the default before any branch so the block never infers a latch.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b10) begin
            winner = 1'b1;
        end else if (req == 2'b11) begin
            winner = ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~lastWinner;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, single-slave bus arbiter: IDLE -> ACCESS -> ACK, one transfer per
// three cycles, round-robin between masters.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.master bus
);

    arbState_t         state;
    logic              owner;
    logic              winner;
    logic [1:0]        reqVec;
    logic [1:0]        gnt;
    logic [1:0]        ack;
    logic              bSel;
    logic              bWrite;
    logic              busy;
    logic [ADDR_W-1:0] bAddr;
    logic [DATA_W-1:0] bWData;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    assign reqVec = {bus.m1_req, bus.m0_req};

    // Pointer advances on the ACCESS->ACK edge, i.e. when the winner's ack is issued.
    rr_arb2 uArb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (reqVec),
        .advance    (state == ACCESS),
        .lastWinner (owner),
        .winner     (winner)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= 1'b0;
            gnt    <= '0;
            ack    <= '0;
            bSel   <= 1'b0;
            bWrite <= 1'b0;
            busy   <= 1'b0;
            bAddr  <= '0;
            bWData <= '0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The command is latched straight into the bus registers, which hold it afterwards.
                    if (|reqVec) begin
                        owner  <= winner;
                        gnt    <= winner ? 2'b10 : 2'b01;
                        bSel   <= 1'b1;
                        busy   <= 1'b1;
                        bWrite <= winner ? bus.m1_write : bus.m0_write;
                        bAddr  <= winner ? bus.m1_addr  : bus.m0_addr;
                        bWData <= winner ? bus.m1_wdata : bus.m0_wdata;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    bSel   <= 1'b0;
                    bWrite <= 1'b0;
                    ack    <= owner ? 2'b10 : 2'b01;
                    if (!bWrite) begin
                        if (owner) begin
                            rdata1 <= bus.bRData;
                        end else begin
                            rdata0 <= bus.bRData;
                        end
                    end
                    state  <= ACK;
                end
                ACK: begin
                    ack   <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack    <= '0;
                    gnt    <= '0;
                    bSel   <= 1'b0;
                    bWrite <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.m0_gnt   = gnt[0];
    assign bus.m1_gnt   = gnt[1];
    assign bus.m0_ack   = ack[0];
    assign bus.m1_ack   = ack[1];
    assign bus.m0_rdata = rdata0;
    assign bus.m1_rdata = rdata1;
    assign bus.bSel     = bSel;
    assign bus.bWrite   = bWrite;
    assign bus.bAddr    = bAddr;
    assign bus.bWData   = bWData;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a small gpio slave model
// (0x0 reads gpioInput, 0x4 is the writable gpioOutput register).
`timescale 1ns/1ps
module tb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] gpioOutput;
    logic [31:0] gpioInput;

    always @(posedge clk) begin
        if (!rst_n) gpioOutput <= '0;
        else if (bus.bSel && bus.bWrite && bus.bAddr == 32'h4) gpioOutput <= bus.bWData;
    end

    assign bus.bRData = (bus.bAddr == 32'h0) ? gpioInput :
                        (bus.bAddr == 32'h4) ? gpioOutput : 32'h0;

    int checks = 0;
    int failures = 0;

    int          cyc;
    int          protoErr;
    logic        hold0;
    logic        hold1;
    int          selCyc[$];
    logic [1:0]  selGnt[$];
    logic        selWr[$];
    logic [31:0] selAddr[$];
    logic [31:0] selData[$];
    int          ackCyc[$];
    logic [1:0]  ackVec[$];
    logic [31:0] ackRdata[$];

    task automatic clear_logs();
        cyc = 0;
        protoErr = 0;
        selCyc.delete(); selGnt.delete(); selWr.delete(); selAddr.delete(); selData.delete();
        ackCyc.delete(); ackVec.delete(); ackRdata.delete();
    endtask

    // Advance one cycle, log bus/ack events, and let masters drop req on ack.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.bSel) begin
            selCyc.push_back(cyc);
            selGnt.push_back({bus.m1_gnt, bus.m0_gnt});
            selWr.push_back(bus.bWrite);
            selAddr.push_back(bus.bAddr);
            selData.push_back(bus.bWData);
        end
        if (bus.m0_ack || bus.m1_ack) begin
            ackCyc.push_back(cyc);
            ackVec.push_back({bus.m1_ack, bus.m0_ack});
            ackRdata.push_back(bus.m1_ack ? bus.m1_rdata : bus.m0_rdata);
        end
        if (!bus.bSel && bus.bWrite) protoErr++;
        if (bus.m0_gnt && bus.m1_gnt) protoErr++;
        if (bus.m0_ack && !bus.m0_gnt) protoErr++;
        if (bus.m1_ack && !bus.m1_gnt) protoErr++;
        if (bus.busy !== (bus.bSel || bus.m0_ack || bus.m1_ack)) protoErr++;
        if (bus.m0_ack && !hold0) bus.m0_req = 1'b0;
        if (bus.m1_ack && !hold1) bus.m1_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({bus.bSel, bus.bWrite, bus.m0_gnt, bus.m1_gnt, bus.m0_ack, bus.m1_ack, bus.busy} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b expected 0000000", {bus.bSel, bus.bWrite, bus.m0_gnt, bus.m1_gnt, bus.m0_ack, bus.m1_ack, bus.busy}); end
        checks++; if (bus.bAddr !== 32'h0) begin failures++; $display("FAIL reset_bAddr: got %h expected 0", bus.bAddr); end
        checks++; if (bus.bWData !== 32'h0) begin failures++; $display("FAIL reset_bWData: got %h expected 0", bus.bWData); end
        checks++; if (bus.m0_rdata !== 32'h0) begin failures++; $display("FAIL reset_m0_rdata: got %h expected 0", bus.m0_rdata); end
        checks++; if (bus.m1_rdata !== 32'h0) begin failures++; $display("FAIL reset_m1_rdata: got %h expected 0", bus.m1_rdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_contention();
        clear_logs();
        bus.m0_write = 1'b1; bus.m0_addr = 32'h4; bus.m0_wdata = 32'h0000_1111; bus.m0_req = 1'b1;
        bus.m1_write = 1'b1; bus.m1_addr = 32'h4; bus.m1_wdata = 32'h0000_2222; bus.m1_req = 1'b1;
        repeat (8) tick();
        checks++; if (ackCyc.size() !== 2) begin failures++; $display("FAIL contention_ack_count: got %0d expected 2", ackCyc.size()); end
        else begin
            checks++; if (ackVec[0] !== 2'b01) begin failures++; $display("FAIL contention_first: got %b expected 01", ackVec[0]); end
            checks++; if (ackVec[1] !== 2'b10) begin failures++; $display("FAIL contention_second: got %b expected 10", ackVec[1]); end
            checks++; if (ackCyc[0] !== 2) begin failures++; $display("FAIL contention_ack_latency: got %0d expected 2", ackCyc[0]); end
            checks++; if (ackCyc[1] - ackCyc[0] !== 3) begin failures++; $display("FAIL contention_ack_gap: got %0d expected 3", ackCyc[1] - ackCyc[0]); end
        end
        checks++; if (selCyc.size() !== 2) begin failures++; $display("FAIL contention_sel_count: got %0d expected 2", selCyc.size()); end
        else begin
            checks++; if (selGnt[0] !== 2'b01 || selData[0] !== 32'h1111) begin
                failures++; $display("FAIL contention_first_bus: got gnt=%b data=%h expected gnt=01 data=00001111", selGnt[0], selData[0]); end
        end
        checks++; if (gpioOutput !== 32'h0000_2222) begin failures++; $display("FAIL contention_gpio: got %h expected 00002222", gpioOutput); end
        checks++; if (protoErr !== 0) begin failures++; $display("FAIL contention_protocol: got %0d violations expected 0", protoErr); end
    endtask

    task automatic test_single_write();
        clear_logs();
        bus.m0_write = 1'b1; bus.m0_addr = 32'h4; bus.m0_wdata = 32'h0000_A5A5; bus.m0_req = 1'b1;
        repeat (5) tick();
        checks++; if (selCyc.size() !== 1) begin failures++; $display("FAIL write_sel_count: got %0d expected 1", selCyc.size()); end
        else begin
            checks++; if (selCyc[0] !== 1) begin failures++; $display("FAIL write_sel_cycle: got %0d expected 1", selCyc[0]); end
            checks++; if (selWr[0] !== 1'b1 || selAddr[0] !== 32'h4 || selGnt[0] !== 2'b01) begin
                failures++; $display("FAIL write_bus: got wr=%b addr=%h gnt=%b expected wr=1 addr=00000004 gnt=01", selWr[0], selAddr[0], selGnt[0]); end
        end
        checks++; if (ackCyc.size() !== 1) begin failures++; $display("FAIL write_ack_count: got %0d expected 1", ackCyc.size()); end
        else begin
            checks++; if (ackCyc[0] !== 2 || ackVec[0] !== 2'b01) begin
                failures++; $display("FAIL write_ack: got cyc=%0d vec=%b expected cyc=2 vec=01", ackCyc[0], ackVec[0]); end
        end
        checks++; if (gpioOutput !== 32'h0000_A5A5) begin failures++; $display("FAIL write_gpio: got %h expected 0000a5a5", gpioOutput); end
        checks++; if (bus.bAddr !== 32'h4 || bus.bWData !== 32'h0000_A5A5 || bus.bWrite !== 1'b0) begin
            failures++; $display("FAIL write_hold: got addr=%h data=%h wr=%b expected 00000004 0000a5a5 0", bus.bAddr, bus.bWData, bus.bWrite); end
        checks++; if (bus.m0_rdata !== 32'h0) begin failures++; $display("FAIL write_rdata_hold: got %h expected 0", bus.m0_rdata); end
    endtask

    task automatic test_single_read();
        clear_logs();
        gpioInput = 32'h0000_1234;
        bus.m1_write = 1'b0; bus.m1_addr = 32'h0; bus.m1_req = 1'b1;
        repeat (5) tick();
        checks++; if (ackCyc.size() !== 1) begin failures++; $display("FAIL read_ack_count: got %0d expected 1", ackCyc.size()); end
        else begin
            checks++; if (ackCyc[0] !== 2 || ackVec[0] !== 2'b10) begin
                failures++; $display("FAIL read_ack: got cyc=%0d vec=%b expected cyc=2 vec=10", ackCyc[0], ackVec[0]); end
            checks++; if (ackRdata[0] !== 32'h0000_1234) begin failures++; $display("FAIL read_rdata_at_ack: got %h expected 00001234", ackRdata[0]); end
        end
        checks++; if (bus.m1_rdata !== 32'h0000_1234) begin failures++; $display("FAIL read_rdata_hold: got %h expected 00001234", bus.m1_rdata); end
        checks++; if (bus.m0_rdata !== 32'h0) begin failures++; $display("FAIL read_m0_untouched: got %h expected 0", bus.m0_rdata); end
        checks++; if (protoErr !== 0) begin failures++; $display("FAIL read_protocol: got %0d violations expected 0", protoErr); end
    endtask

    task automatic test_fairness();
        clear_logs();
        hold0 = 1'b1; hold1 = 1'b1;
        bus.m0_write = 1'b0; bus.m0_addr = 32'h0; bus.m0_req = 1'b1;
        bus.m1_write = 1'b1; bus.m1_addr = 32'h4; bus.m1_wdata = 32'h0000_5555; bus.m1_req = 1'b1;
        for (int i = 0; i < 40 && ackCyc.size() < 6; i++) tick();
        hold0 = 1'b0; hold1 = 1'b0; bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        repeat (4) tick();
        checks++; if (ackCyc.size() !== 6) begin failures++; $display("FAIL fair_ack_count: got %0d expected 6", ackCyc.size()); end
        else begin
            for (int k = 0; k < 6; k++) begin
                checks++; if (ackVec[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    failures++; $display("FAIL fair_order[%0d]: got %b expected %b", k, ackVec[k], (k % 2 == 0) ? 2'b01 : 2'b10); end
                if (k > 0) begin
                    checks++; if (ackCyc[k] - ackCyc[k-1] !== 3) begin
                        failures++; $display("FAIL fair_gap[%0d]: got %0d expected 3", k, ackCyc[k] - ackCyc[k-1]); end
                end
            end
            checks++; if (ackRdata[4] !== 32'h0000_1234) begin failures++; $display("FAIL fair_m0_read: got %h expected 00001234", ackRdata[4]); end
        end
        checks++; if (gpioOutput !== 32'h0000_5555) begin failures++; $display("FAIL fair_gpio: got %h expected 00005555", gpioOutput); end
        checks++; if (protoErr !== 0) begin failures++; $display("FAIL fair_protocol: got %0d violations expected 0", protoErr); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        hold0 = 1'b1;
        bus.m0_write = 1'b1; bus.m0_addr = 32'h4; bus.m0_wdata = 32'h0000_7777; bus.m0_req = 1'b1;
        for (int i = 0; i < 20 && ackCyc.size() < 2; i++) tick();
        hold0 = 1'b0; bus.m0_req = 1'b0;
        repeat (4) tick();
        checks++; if (selCyc.size() !== 2) begin failures++; $display("FAIL b2b_sel_count: got %0d expected 2", selCyc.size()); end
        else begin
            checks++; if (selCyc[0] !== 1 || selCyc[1] - selCyc[0] !== 3) begin
                failures++; $display("FAIL b2b_sel_timing: got first=%0d gap=%0d expected first=1 gap=3", selCyc[0], selCyc[1] - selCyc[0]); end
        end
        checks++; if (ackCyc.size() !== 2) begin failures++; $display("FAIL b2b_ack_count: got %0d expected 2", ackCyc.size()); end
        else begin
            checks++; if (ackCyc[0] !== 2 || ackCyc[1] !== 5 || ackVec[0] !== 2'b01 || ackVec[1] !== 2'b01) begin
                failures++; $display("FAIL b2b_acks: got %0d/%b %0d/%b expected 2/01 5/01", ackCyc[0], ackVec[0], ackCyc[1], ackVec[1]); end
        end
        checks++; if (gpioOutput !== 32'h0000_7777) begin failures++; $display("FAIL b2b_gpio: got %h expected 00007777", gpioOutput); end
    endtask

    task automatic test_reset_mid_transfer();
        clear_logs();
        bus.m0_write = 1'b1; bus.m0_addr = 32'h4; bus.m0_wdata = 32'h0000_DEAD; bus.m0_req = 1'b1;
        tick();
        checks++; if (bus.bSel !== 1'b1) begin failures++; $display("FAIL rstmid_in_access: got bSel=%b expected 1", bus.bSel); end
        rst_n = 1'b0; bus.m0_req = 1'b0;
        tick();
        checks++; if ({bus.bSel, bus.bWrite, bus.m0_gnt, bus.m1_gnt, bus.m0_ack, bus.m1_ack, bus.busy} !== 7'b0) begin
            failures++; $display("FAIL rstmid_ctrl: got %b expected 0000000", {bus.bSel, bus.bWrite, bus.m0_gnt, bus.m1_gnt, bus.m0_ack, bus.m1_ack, bus.busy}); end
        checks++; if (bus.bAddr !== 32'h0 || bus.bWData !== 32'h0) begin
            failures++; $display("FAIL rstmid_bus: got addr=%h data=%h expected 0 0", bus.bAddr, bus.bWData); end
        checks++; if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin
            failures++; $display("FAIL rstmid_rdata: got %h %h expected 0 0", bus.m0_rdata, bus.m1_rdata); end
        tick();
        checks++; if (ackCyc.size() !== 0) begin failures++; $display("FAIL rstmid_no_ack: got %0d acks expected 0", ackCyc.size()); end
        clear_logs();
        rst_n = 1'b1;
        bus.m0_write = 1'b1; bus.m0_addr = 32'h4; bus.m0_wdata = 32'h0000_0A0A; bus.m0_req = 1'b1;
        bus.m1_write = 1'b1; bus.m1_addr = 32'h4; bus.m1_wdata = 32'h0000_0B0B; bus.m1_req = 1'b1;
        repeat (8) tick();
        checks++; if (selGnt.size() !== 2) begin failures++; $display("FAIL rstmid_sel_count: got %0d expected 2", selGnt.size()); end
        else begin
            checks++; if (selGnt[0] !== 2'b01 || selCyc[0] !== 1) begin
                failures++; $display("FAIL rstmid_first_grant: got gnt=%b cyc=%0d expected gnt=01 cyc=1", selGnt[0], selCyc[0]); end
        end
        checks++; if (gpioOutput !== 32'h0000_0B0B) begin failures++; $display("FAIL rstmid_gpio: got %h expected 00000b0b", gpioOutput); end
        checks++; if (protoErr !== 0) begin failures++; $display("FAIL rstmid_protocol: got %0d violations expected 0", protoErr); end
    endtask

    initial begin
        bus.m0_req = 1'b0; bus.m0_write = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_write = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        gpioInput = '0;
        hold0 = 1'b0; hold1 = 1'b0;
        clear_logs();
        test_reset();
        test_contention();
        test_single_write();
        test_single_read();
        test_fairness();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, bus address width.
REQ-002 Parameter: DATA_W, default 32, bus data width.
REQ-003 The block SHALL use a single clock; reset is synchronous and active-low. Ports are clk and rst_n.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- m0_req  in  1  master 0 request; held until ack
- m0_write  in  1  master 0 direction; 1 = write
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_gnt  out  1  master 0 owns the bus
- m0_ack  out  1  master 0 transfer-done pulse
- m0_rdata  out  DATA_W  master 0 read data, valid with m0_ack
- m1_*  (same set as m0_*)  master 1
- bSel  out  1  slave select
- bWrite  out  1  slave write strobe
- bAddr  out  ADDR_W  slave address
- bWData  out  DATA_W  slave write data
- bRData  in  DATA_W  slave read data, combinational from bAddr
- busy  out  1  state is not IDLE

Function
REQ-005 The FSM SHALL have three states: IDLE, ACCESS, ACK.
REQ-006 IDLE: if any mN_req is high, the block SHALL select a winner, latch that master's write/addr/wdata, and go to ACCESS. Otherwise it stays in IDLE.
REQ-007 Arbitration SHALL be round-robin:
- A pointer names the preferred master.
- A sole requester always wins.
- When both request, the preferred master wins.
- The pointer moves to the other master when the winner's ACK is issued.
REQ-008 ACCESS lasts exactly one cycle:
- bSel = 1.
- bWrite/bAddr/bWData come from the latched command.
- The winner's gnt = 1.
- The next state is ACK.
REQ-009 On the ACCESS->ACK edge:
- Read: the block SHALL capture bRData into the winner's rdata.
- Write: the winner's rdata SHALL hold its previous value.
REQ-010 ACK lasts exactly one cycle:
- The winner's ack = 1.
- bSel = 0; gnt stays high.
- The next state is IDLE.
REQ-011 Latency: req sampled in IDLE at edge N -> bSel during cycle N+1 -> ack during cycle N+2. Throughput is at most one transfer per 3 cycles.
REQ-012 Masters SHALL deassert req on the edge that samples ack high. A req still high in the following IDLE cycle is a new transfer.
REQ-013 All bus outputs, gnt, ack and busy SHALL be registered, and ack SHALL be a single-cycle pulse.
REQ-014 When bSel = 0, bWrite SHALL be 0; bAddr and bWData SHALL hold their last values.
REQ-015 Changes to the losing master's req or command during ACCESS/ACK SHALL be ignored until the next IDLE.
REQ-016 Simultaneous first requests after reset SHALL grant master 0.

Reset
REQ-017 When rst_n = 0 at a clock edge, the following SHALL be cleared, regardless of state or any transfer in progress:
- State -> IDLE.
- bSel, bWrite, gnt, ack, busy -> 0.
- bAddr, bWData, m0_rdata, m1_rdata -> 0.
- Pointer -> master 0.
REQ-018 A transfer interrupted by reset SHALL NOT produce ack. The master re-requests after reset.

Structure
REQ-019 The state encoding (IDLE=2'd0, ACCESS=2'd1, ACK=2'd2) and default widths SHALL live in the shared bus package.
REQ-020 The 2-input round-robin winner/pointer logic SHALL be one sub-module, rr_arb2. Everything else SHALL be in bus_arbiter.

Verification
REQ-021 The bench SHALL connect the gpio peripheral as slave and SHALL cover these directed scenarios:
- Single write: m0 writes addr 0x4, data 0x0000_A5A5 -> bSel=1, bWrite=1 in cycle N+1; m0_ack in N+2; gpioOutput = 0xA5A5.
- Single read: gpioInput = 0x1234; m1 reads addr 0x0 -> m1_ack in N+2 with m1_rdata = 0x0000_1234; m0_rdata unchanged.
- Contention: m0 and m1 request together from reset, both writing 0x4 with 0x1111/0x2222 -> m0 served first, then m1. Final gpioOutput = 0x2222. Exactly one ack each, 3 cycles apart.
- Fairness: both hold req continuously for 6 transfers -> grants alternate m0,m1,m0,m1,m0,m1. No two acks within 3 cycles.
- Reset mid-transfer: assert rst_n = 0 during ACCESS -> no ack, all outputs 0, busy = 0 next cycle. After release, the next simultaneous request grants m0.
- Back-to-back: m0 keeps req high after ack -> second transfer starts in the IDLE cycle after ACK; its bSel appears 3 cycles after the first.
